// File: rtl/alu_pkg.sv
// Shared ALU definitions: result-unit codes (matching ALU_FUN[3:2]) and small helpers
// used by both the decoder and the result collector.
package alu_pkg;

   localparam logic [1:0] ARITH_C = 2'b00;
   localparam logic [1:0] LOGIC_C = 2'b01;
   localparam logic [1:0] CMP_C   = 2'b10;
   localparam logic [1:0] SHIFT_C = 2'b11;

   // True when two or more strobes in the vector are high.
   function automatic logic multi_hot(input logic [3:0] flags);
      return (flags & (flags - 4'd1)) != 4'd0;
   endfunction

endpackage : alu_pkg

// File: rtl/alu_res_fifo.sv
// First-word-fall-through FIFO: the head entry is visible on head_o as soon as it is
// written; head_o reads as zero while empty. A push into a full FIFO is accepted only
// when a pop happens on the same edge.
module alu_res_fifo #(
   parameter int W     = 34,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic [W-1:0]  push_data_i,
   input  logic          pop_i,
   output logic [W-1:0]  head_o,
   output logic          valid_o,
   output logic          full_o,
   output logic [AW:0]   level_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          empty_s;
   logic          do_push_s;
   logic          do_pop_s;

   // Handshake qualification and next-state for pointers and occupancy.
   always_comb begin
      empty_s   = (level_q == '0);
      full_o    = (level_q == (AW+1)'(DEPTH));
      do_pop_s  = pop_i & ~empty_s;
      do_push_s = push_i & (~full_o | do_pop_s);
      wr_ptr_d  = do_push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d  = do_pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      case ({do_push_s, do_pop_s})
         2'b10:   level_d = level_q + (AW+1)'(1);
         2'b01:   level_d = level_q - (AW+1)'(1);
         default: level_d = level_q;
      endcase
   end

   // Pointer and occupancy registers; wrap is free because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage array; when full with a simultaneous pop, wr_ptr equals rd_ptr and the
   // departing head slot is reused.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign valid_o = ~empty_s;
   assign head_o  = empty_s ? '0 : mem_q[rd_ptr_q];
   assign level_o = level_q;

endmodule : alu_res_fifo

// File: rtl/alu_result_collector.sv
// Collects results from the four ALU execution units into one FWFT queue, tagging each
// entry with its source unit, and keeps sticky overflow / multi-strobe error flags.
module alu_result_collector
   import alu_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int WIDTH2 = 32,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WIDTH2-1:0]        arith_out,
   input  logic                     arith_flag,
   input  logic [WIDTH-1:0]         logic_out,
   input  logic                     logic_flag,
   input  logic [WIDTH-1:0]         cmp_out,
   input  logic                     cmp_flag,
   input  logic [WIDTH-1:0]         shift_out,
   input  logic                     shift_flag,
   output logic [WIDTH2-1:0]        res_data,
   output logic [1:0]               res_src,
   output logic                     res_valid,
   input  logic                     res_ready,
   input  logic                     clr_err,
   output logic                     ovf_err,
   output logic                     multi_err,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int EW = WIDTH2 + 2;

   logic [3:0]        flags_s;
   logic              push_s;
   logic              pop_s;
   logic              full_s;
   logic [1:0]        sel_src_s;
   logic [WIDTH2-1:0] sel_data_s;
   logic [EW-1:0]     head_s;
   logic              ovf_err_q, ovf_err_d;
   logic              multi_err_q, multi_err_d;

   assign flags_s = {arith_flag, logic_flag, cmp_flag, shift_flag};
   assign push_s  = |flags_s;
   assign pop_s   = res_valid & res_ready;

   // Fixed-priority source select: arith > logic > cmp > shift.
   always_comb begin
      sel_src_s  = ARITH_C;
      sel_data_s = '0;
      if (arith_flag) begin
         sel_src_s  = ARITH_C;
         sel_data_s = arith_out;
      end else if (logic_flag) begin
         sel_src_s  = LOGIC_C;
         sel_data_s = WIDTH2'(logic_out);
      end else if (cmp_flag) begin
         sel_src_s  = CMP_C;
         sel_data_s = WIDTH2'(cmp_out);
      end else if (shift_flag) begin
         sel_src_s  = SHIFT_C;
         sel_data_s = WIDTH2'(shift_out);
      end else begin
         sel_src_s  = ARITH_C;
         sel_data_s = '0;
      end
   end

   alu_res_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (reset),
      .push_i      (push_s),
      .push_data_i ({sel_src_s, sel_data_s}),
      .pop_i       (pop_s),
      .head_o      (head_s),
      .valid_o     (res_valid),
      .full_o      (full_s),
      .level_o     (level)
   );

   // Sticky flags: a set condition on the clearing edge wins over the clear.
   always_comb begin
      ovf_err_d   = (ovf_err_q & ~clr_err) | (push_s & full_s & ~pop_s);
      multi_err_d = (multi_err_q & ~clr_err) | multi_hot(flags_s);
   end

   // Sticky flag registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf_err_q   <= 1'b0;
         multi_err_q <= 1'b0;
      end else begin
         ovf_err_q   <= ovf_err_d;
         multi_err_q <= multi_err_d;
      end
   end

   assign res_data  = head_s[WIDTH2-1:0];
   assign res_src   = head_s[EW-1:WIDTH2];
   assign ovf_err   = ovf_err_q;
   assign multi_err = multi_err_q;

endmodule : alu_result_collector

// File: tb/tb_alu_result_collector.sv
// Self-checking bench for alu_result_collector: a directed vector table, hand-written
// corner sequences and randomized traffic, all compared against a queue-based model.
module tb_alu_result_collector;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] arith_out = '0;
   logic        arith_flag = 1'b0;
   logic [15:0] logic_out = '0;
   logic        logic_flag = 1'b0;
   logic [15:0] cmp_out = '0;
   logic        cmp_flag = 1'b0;
   logic [15:0] shift_out = '0;
   logic        shift_flag = 1'b0;
   logic [31:0] res_data;
   logic [1:0]  res_src;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic        clr_err = 1'b0;
   logic        ovf_err;
   logic        multi_err;
   logic [2:0]  level;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [33:0] mq[$];
   logic        m_ovf = 1'b0;
   logic        m_multi = 1'b0;

   alu_result_collector #(.WIDTH(16), .WIDTH2(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .arith_out(arith_out), .arith_flag(arith_flag),
      .logic_out(logic_out), .logic_flag(logic_flag),
      .cmp_out(cmp_out), .cmp_flag(cmp_flag),
      .shift_out(shift_out), .shift_flag(shift_flag),
      .res_data(res_data), .res_src(res_src), .res_valid(res_valid),
      .res_ready(res_ready), .clr_err(clr_err),
      .ovf_err(ovf_err), .multi_err(multi_err), .level(level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Apply inputs, advance the model over the coming edge from spec-level rules.
   task automatic model_edge(input logic [3:0] fl, input logic [31:0] a,
                             input logic [15:0] l, input logic [15:0] c,
                             input logic [15:0] s, input logic rdy, input logic clr);
      logic        pop;
      logic [33:0] e;
      pop = (mq.size() > 0) && rdy;
      if (fl[3])      e = {2'b00, a};
      else if (fl[2]) e = {2'b01, 16'h0, l};
      else if (fl[1]) e = {2'b10, 16'h0, c};
      else            e = {2'b11, 16'h0, s};
      if (clr) begin
         m_ovf   = 1'b0;
         m_multi = 1'b0;
      end
      if ($countones(fl) > 1) m_multi = 1'b1;
      if (pop) void'(mq.pop_front());
      if (fl != 4'b0000) begin
         if (mq.size() < DEPTH) mq.push_back(e);
         else m_ovf = 1'b1;
      end
   endtask

   task automatic check_model(input string tag);
      logic [33:0] h;
      h = (mq.size() > 0) ? mq[0] : 34'h0;
      chk({tag, ".valid"}, 64'(res_valid), 64'(mq.size() > 0));
      chk({tag, ".data"},  64'(res_data),  64'(h[31:0]));
      chk({tag, ".src"},   64'(res_src),   64'(h[33:32]));
      chk({tag, ".level"}, 64'(level),     64'(mq.size()));
      chk({tag, ".ovf"},   64'(ovf_err),   64'(m_ovf));
      chk({tag, ".multi"}, 64'(multi_err), 64'(m_multi));
   endtask

   // One clock: drive, step model, wait for edge, compare after it.
   task automatic cycle(input string tag, input logic [3:0] fl, input logic [31:0] a,
                        input logic [15:0] l, input logic [15:0] c, input logic [15:0] s,
                        input logic rdy, input logic clr);
      {arith_flag, logic_flag, cmp_flag, shift_flag} = fl;
      arith_out = a; logic_out = l; cmp_out = c; shift_out = s;
      res_ready = rdy; clr_err = clr;
      model_edge(fl, a, l, c, s, rdy, clr);
      @(posedge clk);
      #1;
      check_model(tag);
   endtask

   task automatic idle(input string tag, input logic rdy, input logic clr);
      cycle(tag, 4'b0000, 32'h0, 16'h0, 16'h0, 16'h0, rdy, clr);
   endtask

   typedef struct packed {
      logic [3:0]  fl;
      logic [31:0] a;
      logic [15:0] l;
      logic [15:0] c;
      logic [15:0] s;
      logic        rdy;
      logic        clr;
      logic        ev;
      logic [31:0] ed;
      logic [1:0]  es;
      logic [2:0]  el;
      logic        eo;
      logic        em;
   } vec_t;

   vec_t tab [9];

   initial begin
      // flags order: {arith, logic, cmp, shift}
      tab[0] = '{4'b0010, 32'h0, 16'h0, 16'h0001, 16'h0, 1'b0, 1'b0, 1'b1, 32'h00000001, 2'b10, 3'd1, 1'b0, 1'b0};
      tab[1] = '{4'b0000, 32'h0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 3'd0, 1'b0, 1'b0};
      tab[2] = '{4'b1001, 32'hDEADBEEF, 16'h0, 16'h0, 16'h1234, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 2'b00, 3'd1, 1'b0, 1'b1};
      tab[3] = '{4'b0000, 32'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 2'b00, 3'd1, 1'b0, 1'b0};
      tab[4] = '{4'b0100, 32'h0, 16'hABCD, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 2'b00, 3'd2, 1'b0, 1'b0};
      tab[5] = '{4'b0000, 32'h0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b1, 32'h0000ABCD, 2'b01, 3'd1, 1'b0, 1'b0};
      tab[6] = '{4'b0001, 32'h0, 16'h0, 16'h0, 16'h8001, 1'b1, 1'b0, 1'b1, 32'h00008001, 2'b11, 3'd1, 1'b0, 1'b0};
      tab[7] = '{4'b0000, 32'h0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 3'd0, 1'b0, 1'b0};
      tab[8] = '{4'b0000, 32'h0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 3'd0, 1'b0, 1'b0};

      // Reset state
      #12;
      chk("rst.valid", 64'(res_valid), 64'd0);
      chk("rst.level", 64'(level), 64'd0);
      chk("rst.data",  64'(res_data), 64'd0);
      chk("rst.ovf",   64'(ovf_err), 64'd0);
      @(posedge clk); #1;
      reset = 1'b1;

      // Directed vector table
      for (int i = 0; i < 9; i++) begin
         cycle($sformatf("tab%0d", i), tab[i].fl, tab[i].a, tab[i].l, tab[i].c, tab[i].s,
               tab[i].rdy, tab[i].clr);
         chk($sformatf("tab%0d.valid", i), 64'(res_valid), 64'(tab[i].ev));
         chk($sformatf("tab%0d.data", i),  64'(res_data),  64'(tab[i].ed));
         chk($sformatf("tab%0d.src", i),   64'(res_src),   64'(tab[i].es));
         chk($sformatf("tab%0d.level", i), 64'(level),     64'(tab[i].el));
         chk($sformatf("tab%0d.ovf", i),   64'(ovf_err),   64'(tab[i].eo));
         chk($sformatf("tab%0d.multi", i), 64'(multi_err), 64'(tab[i].em));
      end

      // Fill and overflow: five pushes into a four-deep queue
      for (int i = 1; i <= 5; i++)
         cycle("fill", 4'b1000, 32'(i), 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
      chk("ovf.level", 64'(level), 64'd4);
      chk("ovf.flag",  64'(ovf_err), 64'd1);
      for (int i = 1; i <= 4; i++) begin
         chk("ovf.order", 64'(res_data), 64'(i));
         idle("drain", 1'b1, 1'b0);
      end
      chk("ovf.empty", 64'(res_valid), 64'd0);
      idle("clr", 1'b0, 1'b1);
      chk("ovf.cleared", 64'(ovf_err), 64'd0);

      // Full with simultaneous push and pop
      for (int i = 0; i < 4; i++)
         cycle("fill2", 4'b1000, 32'h10 + 32'(i), 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
      cycle("fullpp", 4'b0100, 32'h0, 16'h0077, 16'h0, 16'h0, 1'b1, 1'b0);
      chk("fullpp.level", 64'(level), 64'd4);
      chk("fullpp.ovf",   64'(ovf_err), 64'd0);
      for (int i = 0; i < 3; i++) idle("drain2", 1'b1, 1'b0);
      chk("fullpp.last.data", 64'(res_data), 64'h77);
      chk("fullpp.last.src",  64'(res_src), 64'd1);
      idle("drain2", 1'b1, 1'b0);

      // Clear on the same edge as a new multi-strobe: flag ends set
      cycle("mset", 4'b0110, 32'h0, 16'h5, 16'h6, 16'h0, 1'b1, 1'b0);
      cycle("mclrset", 4'b0011, 32'h0, 16'h0, 16'h7, 16'h8, 1'b1, 1'b1);
      chk("mclrset.multi", 64'(multi_err), 64'd1);
      idle("mclr", 1'b1, 1'b1);
      idle("mclr2", 1'b1, 1'b0);

      // Wrap-around with stalls
      for (int i = 0; i < 10; i++) begin
         cycle("wrap.push", 4'b0001, 32'h0, 16'h0, 16'h0, 16'(100 + i), 1'b0, 1'b0);
         if (i % 2 == 1) idle("wrap.stall", 1'b0, 1'b0);
         chk("wrap.order", 64'(res_data), 64'(100 + i));
         idle("wrap.pop", 1'b1, 1'b0);
      end
      chk("wrap.ovf",   64'(ovf_err), 64'd0);
      chk("wrap.multi", 64'(multi_err), 64'd0);

      // Reset mid-operation
      for (int i = 0; i < 3; i++)
         cycle("pre_rst", 4'b1000, 32'hA0 + 32'(i), 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
      chk("pre_rst.level", 64'(level), 64'd3);
      #3;
      reset = 1'b0;
      #1;
      chk("async_rst.valid", 64'(res_valid), 64'd0);
      chk("async_rst.level", 64'(level), 64'd0);
      chk("async_rst.data",  64'(res_data), 64'd0);
      chk("async_rst.src",   64'(res_src), 64'd0);
      mq.delete();
      m_ovf = 1'b0;
      m_multi = 1'b0;
      arith_flag = 1'b1;
      @(posedge clk); #1;
      chk("in_rst.level", 64'(level), 64'd0);
      arith_flag = 1'b0;
      reset = 1'b1;
      cycle("post_rst", 4'b1000, 32'h55, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
      chk("post_rst.level", 64'(level), 64'd1);

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         logic [3:0] fl;
         int r;
         r = $urandom_range(0, 15);
         if (r < 5)       fl = 4'b0000;
         else if (r < 13) fl = 4'b0001 << $urandom_range(0, 3);
         else             fl = 4'($urandom_range(1, 15));
         cycle("rand", fl, $urandom, 16'($urandom), 16'($urandom), 16'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_alu_result_collector

// File: doc/alu_result_collector.md
ALU_RESULT_COLLECTOR -- requirements
Module: alu_result_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the operand width and the width of the logic, cmp and shift results.
REQ-002 SHALL have parameter WIDTH2, default 32, meaning the arith result width and the output data width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning the number of FIFO entries; it SHALL be a power of two and at least 2.
REQ-004 SHALL have port `clk`, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port `reset`, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports `arith_out` (input, WIDTH2) and `arith_flag` (input, 1): the arith unit result and its valid strobe.
REQ-007 SHALL have ports `logic_out` (input, WIDTH) and `logic_flag` (input, 1): the logic unit result and its valid strobe.
REQ-008 SHALL have ports `cmp_out` (input, WIDTH) and `cmp_flag` (input, 1): the compare unit result and its valid strobe.
REQ-009 SHALL have ports `shift_out` (input, WIDTH) and `shift_flag` (input, 1): the shift unit result and its valid strobe.
REQ-010 SHALL have port `res_data`, output, WIDTH2: the head-of-FIFO result.
REQ-011 SHALL have port `res_src`, output, 2 bits: the source unit code of the head entry.
REQ-012 SHALL have port `res_valid`, output, 1 bit: the head entry is valid.
REQ-013 SHALL have port `res_ready`, input, 1 bit: the consumer accepts the head entry.
REQ-014 SHALL have port `clr_err`, input, 1 bit: synchronous clear of the sticky error flags.
REQ-015 SHALL have port `ovf_err`, output, 1 bit: sticky flag, a result was dropped because the FIFO was full.
REQ-016 SHALL have port `multi_err`, output, 1 bit: sticky flag, more than one unit flag was high in the same cycle.
REQ-017 SHALL have port `level`, output, $clog2(DEPTH)+1 bits: the current FIFO occupancy.

Function
REQ-018 SHALL encode the unit codes as arith=2'b00, logic=2'b01, cmp=2'b10, shift=2'b11, matching the ALU_FUN[3:2] decode.
REQ-019 SHALL treat a push request as the OR of the four flags, sampled on each rising edge.
REQ-020 SHALL zero-extend the WIDTH-bit results to WIDTH2 before storing them.
REQ-021 SHALL, when several flags are high together, store one entry chosen by priority arith > logic > cmp > shift, and set multi_err on the same edge.
REQ-022 SHALL implement a first-word-fall-through FIFO: a push at edge n makes res_valid=1 immediately after edge n, so latency is 1 cycle.
REQ-023 SHALL pop on an edge where res_valid and res_ready are both 1; res_ready is ignored while res_valid is 0.
REQ-024 SHALL drive res_data and res_src to 0 while the FIFO is empty.
REQ-025 SHALL hold res_data and res_src stable while res_valid=1 and res_ready=0.
REQ-026 SHALL, with a push and a pop on the same edge, perform both and leave level unchanged; this holds when full (no drop) and when holding one entry.
REQ-027 SHALL, on a push when full with no pop on that edge, drop the new result, leave the contents unchanged, and set ovf_err.
REQ-028 SHALL not underflow: a pop is impossible when empty.
REQ-029 SHALL let read and write pointers wrap modulo DEPTH with no bubble.
REQ-030 SHALL clear both sticky flags on an edge with clr_err=1; if a set condition occurs on that same edge, the flag SHALL end at 1.

Reset
REQ-031 SHALL, when reset is low, asynchronously clear the pointers, level, ovf_err and multi_err, and force res_valid=0, res_data=0 and res_src=0.
REQ-032 SHALL discard all FIFO contents on reset mid-operation; flags asserted during reset are ignored.
REQ-033 SHALL release reset synchronously; the first push is possible on the first edge after deassertion.

Structure
REQ-034 SHALL take the unit-code constants (ARITH_C, LOGIC_C, CMP_C, SHIFT_C) from a shared package, alu_pkg, shared with the decoder.
REQ-035 SHALL contain one sub-module, alu_res_fifo, a parameterised FWFT FIFO (width WIDTH2+2, DEPTH), instantiated once; the select/priority logic and the sticky flags stay in the top.

Verification
REQ-036 Single push: cmp_flag=1 for 1 cycle with cmp_out=16'h0001 -> next cycle res_valid=1, res_data=32'h00000001, res_src=2'b10, level=1.
REQ-037 Fill and overflow: 5 arith pushes (1..5) with res_ready=0 -> level=4, ovf_err=1, pops then return 1,2,3,4 in order.
REQ-038 Full with simultaneous push and pop: at level=4, logic_flag=1 and res_ready=1 on the same edge -> level stays 4, ovf_err stays 0, the new entry is last out.
REQ-039 Multi-flag: arith_flag=1 (32'hDEADBEEF) together with shift_flag=1 -> one entry, res_data=32'hDEADBEEF, res_src=2'b00, multi_err=1; then clr_err=1 -> multi_err=0.
REQ-040 Reset mid-operation: level=3, then reset low mid-cycle -> res_valid=0 and level=0 immediately, without waiting for an edge; after release, one push yields level=1.
REQ-041 Wrap-around: 10 interleaved push/pop pairs with stalled res_ready cycles -> output order equals input order and no error flags are set.
